// File: rtl/ula_pkg.sv
// Shared op codes, FSM state encoding and small helpers for the bit-serial ALU.
package ula_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_NOTA  = 3'b101;
  localparam logic [2:0] OP_CMP   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // SUB and CMP both run A + ~B + 1 through the slice
  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/ula_bit_slice.sv
// One-bit ALU slice: sum/carry, bitwise logic and the LSB-first compare chain.
module ula_bit_slice
  import ula_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_cin,
  input  logic       i_lt,
  input  logic       i_eq,
  output logic       o_f,
  output logic       o_cout,
  output logic       o_lt,
  output logic       o_eq
);

  logic w_b_eff;
  logic w_sum;
  logic w_diff;

  assign w_b_eff = i_b ^ op_is_sub(i_op);
  assign w_sum   = i_a ^ w_b_eff ^ i_cin;
  assign w_diff  = i_a ^ i_b;

  always_comb begin
    o_f    = 1'b0;
    o_cout = (i_a & w_b_eff) | (i_cin & (i_a ^ w_b_eff));
    // Higher bits override lower ones, so the chain settles on the MSB decision
    o_lt   = (~i_a & i_b) | (~w_diff & i_lt);
    o_eq   = i_eq & ~w_diff;
    case (i_op)
      OP_ADD,
      OP_SUB:   o_f = w_sum;
      OP_AND:   o_f = i_a & i_b;
      OP_OR:    o_f = i_a | i_b;
      OP_XOR:   o_f = w_diff;
      OP_NOTA:  o_f = ~i_a;
      OP_CMP:   o_f = 1'b0;
      OP_PASSB: o_f = i_b;
      default:  o_f = 1'b0;
    endcase
  end

endmodule

// File: rtl/ula_serial.sv
// Bit-serial ALU: one reused 1-bit slice, LSB first, WIDTH bit-cycles then a DONE cycle.
// Optional signed compare output menor_s is built when ULA_SIGNED_CMP_EN is defined.
module ula_serial
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] F,
  output logic             carry,
  output logic             igual,
  output logic             menor,
  output logic             zero,
  output logic             busy,
`ifdef ULA_SIGNED_CMP_EN
  output logic             done,
  output logic             menor_s
`else
  output logic             done
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic [2:0]       r_op;
  logic             r_c;
  logic             r_lt;
  logic             r_eq;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] r_f;
  logic             r_carry;
  logic             r_igual;
  logic             r_menor;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;

  logic             w_f;
  logic             w_cout;
  logic             w_lt;
  logic             w_eq;
  logic [WIDTH-1:0] w_res_new;
  logic [WIDTH-1:0] w_f_final;

  ula_bit_slice u_slice (
    .i_op   (r_op),
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_c),
    .i_lt   (r_lt),
    .i_eq   (r_eq),
    .o_f    (w_f),
    .o_cout (w_cout),
    .o_lt   (w_lt),
    .o_eq   (w_eq)
  );

  assign w_res_new = {w_f, r_res};
  assign w_f_final = (r_op == OP_CMP) ? '0 : w_res_new;

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state; start is only honoured in IDLE or DONE
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_state_nxt = ST_DONE;
          w_last      = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_op    <= OP_ADD;
      r_c     <= 1'b0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b1;
      r_cnt   <= '0;
      r_f     <= '0;
      r_carry <= 1'b0;
      r_igual <= 1'b1;
      r_menor <= 1'b0;
      r_zero  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_RUN);
      r_done <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_a   <= A;
        r_b   <= B;
        r_op  <= op;
        r_c   <= op_is_sub(op);
        r_lt  <= 1'b0;
        r_eq  <= 1'b1;
        r_cnt <= '0;
        r_res <= '0;
      end else if (r_state == ST_RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_c   <= w_cout;
        r_lt  <= w_lt;
        r_eq  <= w_eq;
        r_res <= w_res_new[WIDTH-1:1];
        if (w_last) begin
          r_f     <= w_f_final;
          r_carry <= ((r_op == OP_ADD) || op_is_sub(r_op)) ? w_cout : 1'b0;
          r_igual <= w_eq;
          r_menor <= w_lt;
          r_zero  <= (w_f_final == '0);
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef ULA_SIGNED_CMP_EN
  logic r_menor_s;
  logic w_lt_s;

  // At the MSB bit-cycle differing sign bits decide; equal sign bits defer to the chain
  assign w_lt_s = (r_a[0] & ~r_b[0]) | (~(r_a[0] ^ r_b[0]) & w_lt);

  always_ff @(posedge clock) begin
    if (reset)                            r_menor_s <= 1'b0;
    else if ((r_state == ST_RUN) && w_last) r_menor_s <= w_lt_s;
  end

  assign menor_s = r_menor_s;
`endif

  assign F     = r_f;
  assign carry = r_carry;
  assign igual = r_igual;
  assign menor = r_menor;
  assign zero  = r_zero;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_ula_serial.sv
// Directed self-checking bench for ula_serial (WIDTH=8) with hand-computed expectations.
module tb_ula_serial;
  import ula_pkg::*;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] F;
  logic         carry;
  logic         igual;
  logic         menor;
  logic         zero;
  logic         busy;
  logic         done;
`ifdef ULA_SIGNED_CMP_EN
  logic         menor_s;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  ula_serial #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .F       (F),
    .carry   (carry),
    .igual   (igual),
    .menor   (menor),
    .zero    (zero),
    .busy    (busy),
`ifdef ULA_SIGNED_CMP_EN
    .done    (done),
    .menor_s (menor_s)
`else
    .done    (done)
`endif
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request through its accepting edge, then scramble the inputs
  task automatic launch(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op    = o;
    A     = a;
    B     = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = ~o;
    A     = ~a;
    B     = ~b;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((done !== 1'b1) && (n < 20));
  endtask

  // Latency n counts edges after the accepting edge: done occupies the (W+1)th cycle
  task automatic check_result(input string tag, input int n, input logic [W-1:0] f,
                              input logic c, input logic eq, input logic lt, input logic z);
    check({tag, " latency"}, 32'(n), 32'(W));
    check({tag, " done"},    32'(done),  32'(1'b1));
    check({tag, " F"},       32'(F),     32'(f));
    check({tag, " carry"},   32'(carry), 32'(c));
    check({tag, " igual"},   32'(igual), 32'(eq));
    check({tag, " menor"},   32'(menor), 32'(lt));
    check({tag, " zero"},    32'(zero),  32'(z));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;

    reset = 1'b1;
    start = 1'b0;
    op    = OP_ADD;
    A     = '0;
    B     = '0;
    tick();
    tick();
    check("rst F",     32'(F),     32'(0));
    check("rst carry", 32'(carry), 32'(0));
    check("rst igual", 32'(igual), 32'(1));
    check("rst menor", 32'(menor), 32'(0));
    check("rst zero",  32'(zero),  32'(1));
    check("rst busy",  32'(busy),  32'(0));
    check("rst done",  32'(done),  32'(0));
`ifdef ULA_SIGNED_CMP_EN
    check("rst menor_s", 32'(menor_s), 32'(0));
`endif
    reset = 1'b0;
    tick();
    check("idle busy", 32'(busy), 32'(0));

    // ADD with carry out
    launch(OP_ADD, 8'hF0, 8'h20);
    check("add busy", 32'(busy), 32'(1));
    wait_done(n);
    check_result("add", n, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("add pulse", 32'(done), 32'(0));
    check("add hold",  32'(F),    32'(8'h10));
    check("add idle",  32'(busy), 32'(0));

    launch(OP_SUB, 8'h5A, 8'h5A);
    wait_done(n);
    check_result("sub_eq", n, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();

    launch(OP_CMP, 8'h03, 8'h80);
    wait_done(n);
    check_result("cmp", n, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef ULA_SIGNED_CMP_EN
    check("cmp menor_s", 32'(menor_s), 32'(0));
`endif
    tick();

    launch(OP_XOR, 8'hAA, 8'hFF);
    wait_done(n);
    check_result("xor", n, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    launch(OP_NOTA, 8'h0F, 8'h0F);
    wait_done(n);
    check_result("nota", n, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    launch(OP_PASSB, 8'h12, 8'h00);
    wait_done(n);
    check_result("passb", n, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    launch(OP_ADD, 8'hFF, 8'h01);
    wait_done(n);
    check_result("add_wrap", n, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();

    // Start during RUN must not disturb the operation in progress
    launch(OP_ADD, 8'h01, 8'h02);
    tick();
    tick();
    tick();
    op    = OP_SUB;
    A     = 8'hFF;
    B     = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign busy", 32'(busy), 32'(1));
    wait_done(n);
    check_result("ign", n + 4, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);

    // Start in the DONE cycle chains straight into the next operation
    op    = OP_OR;
    A     = 8'h0F;
    B     = 8'h30;
    start = 1'b1;
    tick();
    start = 1'b0;
    A     = 8'h00;
    B     = 8'h00;
    check("chain pulse", 32'(done), 32'(0));
    check("chain busy",  32'(busy), 32'(1));
    wait_done(n);
    check_result("chain", n, 8'h3F, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    // Reset at bit-cycle 4 aborts; start held with reset is ignored
    launch(OP_AND, 8'hFF, 8'hFF);
    tick();
    tick();
    tick();
    tick();
    reset = 1'b1;
    start = 1'b1;
    op    = OP_ADD;
    A     = 8'h11;
    B     = 8'h22;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("abort busy",  32'(busy),  32'(0));
    check("abort done",  32'(done),  32'(0));
    check("abort F",     32'(F),     32'(0));
    check("abort igual", 32'(igual), 32'(1));
    check("abort zero",  32'(zero),  32'(1));
    check("abort carry", 32'(carry), 32'(0));
    check("abort menor", 32'(menor), 32'(0));
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check("abort no done", 32'(pulses), 32'(0));

    launch(OP_SUB, 8'h03, 8'h80);
    wait_done(n);
    check_result("sub_borrow", n, 8'h83, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
